// File: rtl/aec_feeder_if.sv
// Handshake bundle between the expression source, the feeder and the calculator.
// The slave modport is the feeder's view; master is the source/calculator side.
interface aec_feeder_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       aec_ready;
    logic [7:0] aec_ascii;
    logic       aec_valid;

    modport slave (
        input  in_valid, in_data, aec_valid,
        output in_ready, aec_ready, aec_ascii
    );

    modport master (
        output in_valid, in_data, aec_valid,
        input  in_ready, aec_ready, aec_ascii
    );
endinterface

// File: rtl/aec_feeder.sv
// Expression feeder: filters/validates one ASCII expression, buffers it, replays it as a burst.
// Optional macro AEC_FEED_TIMEOUT_EN adds a TIMEOUT-cycle watchdog on the calculator result.
module aec_feeder #(
    parameter int MAX_LEN = 16
`ifdef AEC_FEED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    aec_feeder_if.slave    bus,
    output logic           err,
    output logic           busy
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_EQ = 8'h3D;
    localparam logic [7:0] CH_LP = 8'h28;
    localparam logic [7:0] CH_RP = 8'h29;

    typedef enum logic [1:0] {COLLECT, PLAY, WAIT} state_t;

    state_t        state, state_n;
    logic [7:0]    buf_mem [MAX_LEN];
    logic [LW-1:0] len, len_n, depth, depth_n, idx, idx_n;
    logic          errflag, errflag_n;
    logic          aec_ready_n, err_n, wr_en;
    logic [7:0]    ascii_n;
    logic [7:0]    c;
    logic          is_legal;

`ifdef AEC_FEED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt, cnt_n;
`endif

    assign c        = bus.in_data;
    assign is_legal = c inside {[8'h30:8'h39], [8'h61:8'h66], 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2D};
    // Gated by rst_n so the source sees no acceptance while reset is held.
    assign bus.in_ready = rst_n && (state == COLLECT);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_n     = state;
        len_n       = len;
        depth_n     = depth;
        idx_n       = idx;
        errflag_n   = errflag;
        aec_ready_n = 1'b0;
        ascii_n     = 8'h00;
        err_n       = 1'b0;
        wr_en       = 1'b0;
`ifdef AEC_FEED_TIMEOUT_EN
        cnt_n       = cnt;
`endif
        case (state)
            COLLECT: begin
                if (bus.in_valid) begin
                    if (c == CH_EQ) begin
                        if (errflag || depth != '0 || len == '0) begin
                            err_n     = 1'b1;
                            len_n     = '0;
                            depth_n   = '0;
                            errflag_n = 1'b0;
                        end else begin
                            // First character is loaded here so it appears the cycle after '='.
                            state_n     = PLAY;
                            aec_ready_n = 1'b1;
                            ascii_n     = buf_mem[0];
                            idx_n       = LW'(1);
                        end
                    end else if (c == CH_SP || errflag) begin
                        // Spaces are dropped; after an error bytes are swallowed until '='.
                    end else if (!is_legal || len == LW'(MAX_LEN) || (c == CH_RP && depth == '0)) begin
                        errflag_n = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        len_n = len + 1'b1;
                        if (c == CH_LP)      depth_n = depth + 1'b1;
                        else if (c == CH_RP) depth_n = depth - 1'b1;
                    end
                end
            end
            PLAY: begin
                // The buffer never holds '=', so seeing it on the output marks the last burst cycle.
                if (bus.aec_ascii == CH_EQ) begin
                    state_n = WAIT;
`ifdef AEC_FEED_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end else if (idx == len) begin
                    ascii_n = CH_EQ;
                end else begin
                    ascii_n = buf_mem[idx[AW-1:0]];
                    idx_n   = idx + 1'b1;
                end
            end
            WAIT: begin
                if (bus.aec_valid) begin
                    state_n   = COLLECT;
                    len_n     = '0;
                    depth_n   = '0;
                    errflag_n = 1'b0;
                end
`ifdef AEC_FEED_TIMEOUT_EN
                else if (cnt == TW'(TIMEOUT - 1)) begin
                    err_n     = 1'b1;
                    state_n   = COLLECT;
                    len_n     = '0;
                    depth_n   = '0;
                    errflag_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`endif
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= COLLECT;
            len           <= '0;
            depth         <= '0;
            idx           <= '0;
            errflag       <= 1'b0;
            bus.aec_ready <= 1'b0;
            bus.aec_ascii <= 8'h00;
            err           <= 1'b0;
            busy          <= 1'b0;
`ifdef AEC_FEED_TIMEOUT_EN
            cnt           <= '0;
`endif
        end else begin
            state         <= state_n;
            len           <= len_n;
            depth         <= depth_n;
            idx           <= idx_n;
            errflag       <= errflag_n;
            bus.aec_ready <= aec_ready_n;
            bus.aec_ascii <= ascii_n;
            err           <= err_n;
            busy          <= (state_n != COLLECT);
`ifdef AEC_FEED_TIMEOUT_EN
            cnt           <= cnt_n;
`endif
        end
    end

    // NOTE: the character buffer has no reset; len alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[len[AW-1:0]] <= c;
    end
endmodule

// File: tb/tb_aec_feeder.sv
// Scoreboard bench for aec_feeder: a string-level model predicts each replay burst or err pulse.
// Define AEC_FEED_TIMEOUT_EN to also exercise the result-wait watchdog with TIMEOUT=8.
module tb_aec_feeder;
    logic clk = 1'b0;
    logic rst_n;
    logic err, busy;

    aec_feeder_if bus();

`ifdef AEC_FEED_TIMEOUT_EN
    aec_feeder #(.MAX_LEN(16), .TIMEOUT(8)) dut (
`else
    aec_feeder #(.MAX_LEN(16)) dut (
`endif
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .err  (err),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;
    int         err_seen = 0;
    int         err_exp = 0;
    bit         in_burst = 1'b0;
    logic [8:0] exp_q[$];
    logic [7:0] mdl_q[$];
    logic [8:0] mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: every non-idle output cycle must match the next expected {aec_ready, aec_ascii}.
    always @(negedge clk) begin
        if (err) err_seen++;
        if (bus.aec_ready || bus.aec_ascii != 8'h00) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {23'd0, bus.aec_ready, bus.aec_ascii}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("replay", {23'd0, bus.aec_ready, bus.aec_ascii}, {23'd0, mon_e});
                in_burst = (mon_e[7:0] != 8'h3D);
            end
        end else if (in_burst) begin
            check("burst_gap", 32'd0, 32'd1);
            in_burst = 1'b0;
        end
    end

    function automatic bit legal(input logic [7:0] ch);
        return (ch >= 8'h30 && ch <= 8'h39) || (ch >= 8'h61 && ch <= 8'h66) ||
               ch == 8'h28 || ch == 8'h29 || ch == 8'h2A || ch == 8'h2B || ch == 8'h2D;
    endfunction

    // Fills mdl_q with the characters that should be replayed; returns 1 if the expression is dropped.
    function automatic bit model(input string s);
        int         depth = 0;
        bit         ef = 1'b0;
        logic [7:0] ch;
        mdl_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            if (ch == 8'h3D) break;
            if (ch == 8'h20 || ef) continue;
            if (!legal(ch) || mdl_q.size() == 16 || (ch == 8'h29 && depth == 0)) begin
                ef = 1'b1;
            end else begin
                mdl_q.push_back(ch);
                if (ch == 8'h28) depth++;
                else if (ch == 8'h29) depth--;
            end
        end
        return ef || depth != 0 || mdl_q.size() == 0;
    endfunction

    task automatic drive_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_burst_done();
        int t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            check("burst_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
            in_burst = 1'b0;
        end
    endtask

    // Sends s byte by byte (idle gap every third byte when gap>0) and checks the outcome.
    task automatic run_expr(input string s, input int gap, input bit hold_valid);
        bit         bad;
        logic [7:0] ch;
        bad = model(s);
        if (!bad) begin
            foreach (mdl_q[k]) exp_q.push_back({(k == 0), mdl_q[k]});
            exp_q.push_back({1'b0, 8'h3D});
        end
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            drive_byte(ch);
            if (ch == 8'h3D) break;
            if (gap > 0 && (i % 3) == 2) idle(gap);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        if (bad) begin
            err_exp++;
            check("bad_err", {31'd0, err}, 32'd1);
            check("bad_no_start", {31'd0, bus.aec_ready}, 32'd0);
            check("bad_in_ready", {31'd0, bus.in_ready}, 32'd1);
            @(negedge clk);
            check("bad_err_width", {31'd0, err}, 32'd0);
        end else begin
            check("first_start", {30'd0, bus.aec_ready, err}, 32'd2);
            wait_burst_done();
            @(negedge clk);
            check("wait_idle", {22'd0, busy, bus.in_ready, bus.aec_ascii}, {22'd0, 1'b1, 1'b0, 8'h00});
            if (!hold_valid) begin
                repeat (3) @(negedge clk);
                check("wait_hold", {31'd0, bus.in_ready}, 32'd0);
                bus.aec_valid = 1'b1;
                @(negedge clk);
                bus.aec_valid = 1'b0;
                check("ready_after_valid", {30'd0, bus.in_ready, busy}, 32'd2);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        string s16;
        string s17;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.aec_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_vals", {20'd0, bus.in_ready, bus.aec_ready, bus.aec_ascii, err, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset", {30'd0, bus.in_ready, busy}, 32'd2);

        run_expr("3+4=", 0, 1'b0);
        run_expr("( 2 + a ) * 3 =", 2, 1'b0);
        run_expr("2+g=", 0, 1'b0);
        run_expr("1=", 0, 1'b0);
        run_expr(")1(=", 1, 1'b0);
        run_expr("(1=", 0, 1'b0);
        run_expr("=", 0, 1'b0);
        s17 = "12345678901234567=";
        run_expr(s17, 0, 1'b0);
        s16 = "1234567890abcdef=";
        run_expr(s16, 0, 1'b0);
        run_expr("(9-8)*(7+6)=", 0, 1'b0);

        // A stray result pulse while collecting must be ignored.
        @(negedge clk);
        bus.aec_valid = 1'b1;
        @(negedge clk);
        bus.aec_valid = 1'b0;
        check("valid_in_collect", {30'd0, bus.in_ready, busy}, 32'd2);

        // Reset in the middle of a replay abandons the burst at once.
        void'(model("12345="));
        foreach (mdl_q[k]) exp_q.push_back({(k == 0), mdl_q[k]});
        exp_q.push_back({1'b0, 8'h3D});
        foreach (mdl_q[k]) drive_byte(mdl_q[k]);
        drive_byte(8'h3D);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_play", {20'd0, bus.in_ready, bus.aec_ready, bus.aec_ascii, err, busy}, 32'd0);
        exp_q.delete();
        in_burst = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_mid_reset", {30'd0, bus.in_ready, busy}, 32'd2);
        run_expr("a+b=", 0, 1'b0);

`ifdef AEC_FEED_TIMEOUT_EN
        run_expr("1=", 0, 1'b1);
        repeat (7) @(negedge clk);
        check("timeout_early", {31'd0, err}, 32'd0);
        @(negedge clk);
        err_exp++;
        check("timeout_err", {29'd0, err, busy, bus.in_ready}, 32'd5);
        @(negedge clk);
        check("timeout_err_width", {31'd0, err}, 32'd0);
        run_expr("5*5=", 0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        check("err_count", err_seen, err_exp);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
